// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: opcode and FSM state encodings.
package usr_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHR   = 3'b010,
    OP_SHL   = 3'b011,
    OP_CLEAR = 3'b100,
    OP_ROR   = 3'b101,
    OP_ROL   = 3'b110,
    OP_ASR   = 3'b111
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/usr_step.sv
// Combinational single-step shifter: computes one shift/rotate step of q.
// Ports:
//   q       - current register value
//   op      - operation; non-shift ops pass q through unchanged
//   sin     - serial-in bit used by SHR (fills MSB) and SHL (fills LSB)
//   q_nxt_c - value after one step
//   cout_c  - bit shifted or rotated out by this step
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  op_t              op,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt_c,
  output logic             cout_c
);

  // One bit position per evaluation.
  always_comb begin
    q_nxt_c = q;
    cout_c  = 1'b0;
    case (op)
      OP_SHR: begin
        q_nxt_c = {sin, q[WIDTH-1:1]};
        cout_c  = q[0];
      end
      OP_SHL: begin
        q_nxt_c = {q[WIDTH-2:0], sin};
        cout_c  = q[WIDTH-1];
      end
      OP_ROR: begin
        q_nxt_c = {q[0], q[WIDTH-1:1]};
        cout_c  = q[0];
      end
      OP_ROL: begin
        q_nxt_c = {q[WIDTH-2:0], q[WIDTH-1]};
        cout_c  = q[WIDTH-1];
      end
      OP_ASR: begin
        q_nxt_c = {q[WIDTH-1], q[WIDTH-1:1]};
        cout_c  = q[0];
      end
      default: begin
        q_nxt_c = q;
        cout_c  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/load/clear plus multi-cycle shifts and rotates,
// one bit position per clock, behind a valid/ready command port.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   cmd_valid/cmd_ready - command handshake; ready only while idle
//   op, amt, din, sin   - opcode, step count, load data, serial-in (sampled each step)
//   abort               - cancels an in-progress shift, keeping partial results
//   q, cout             - register contents and last bit shifted out
//   busy, done          - shift in progress; one-cycle completion pulse
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   count_q, count_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;

  op_t                op_in;
  op_t                step_op;
  logic [WIDTH-1:0]   step_q;
  logic               step_cout;

  assign op_in = op_t'(op);

  // The first step happens on the accept edge, so the shifter sees the live
  // opcode while idle and the latched one while shifting.
  assign step_op = (state_q == IDLE) ? op_in : op_q;

  usr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q       (q_q),
    .op      (step_op),
    .sin     (sin),
    .q_nxt_c (step_q),
    .cout_c  (step_cout)
  );

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= OP_HOLD;
      q_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      q_q     <= q_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    q_d     = q_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = op_in;
          done_d = 1'b1;
          case (op_in)
            OP_HOLD: ;
            OP_LOAD: begin
              q_d    = din;
              cout_d = 1'b0;
            end
            OP_CLEAR: begin
              q_d    = '0;
              cout_d = 1'b0;
            end
            default: begin
              // Shift ops: amt of zero degenerates to HOLD.
              if (amt != '0) begin
                q_d    = step_q;
                cout_d = step_cout;
                if (amt != AMT_W'(1)) begin
                  state_d = SHIFT;
                  count_d = amt - AMT_W'(1);
                  done_d  = 1'b0;
                end
              end
            end
          endcase
        end
      end

      SHIFT: begin
        // Abort wins over the step and suppresses done.
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          q_d     = step_q;
          cout_d  = step_cout;
          count_d = count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign q         = q_q;
  assign cout      = cout_q;
  assign done      = done_q;
  assign busy      = (state_q == SHIFT);
  assign cmd_ready = (state_q == IDLE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=4, AMT_W=3).
// Stimulus pushes the expected final q/cout per command; a monitor pops and
// compares whenever done pulses.
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned AW = 3;

  typedef struct {
    logic [W-1:0] q;
    logic         cout;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [W-1:0]  din;
  logic          sin;
  logic          abort;
  logic [W-1:0]  q;
  logic          cout;
  logic          busy;
  logic          done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  universal_shift_reg #(
    .WIDTH (W),
    .AMT_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op        (op),
    .amt       (amt),
    .din       (din),
    .sin       (sin),
    .abort     (abort),
    .q         (q),
    .cout      (cout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] eq, input logic ec);
    exp_t e;
    e.q    = eq;
    e.cout = ec;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [2:0] o, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic s);
    int n;
    op        = o;
    amt       = a;
    din       = d;
    sin       = s;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(cmd_ready), 32'd1);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 q=%b, expected no done", q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_q", 32'(q), 32'(e.q));
          check("done_cout", 32'(cout), 32'(e.cout));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    op        = 3'b000;
    amt       = '0;
    din       = '0;
    sin       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    // 1: LOAD, done is a single-cycle pulse
    push(4'b1011, 1'b0);
    send(OP_LOAD, 3'd0, 4'b1011, 1'b0);
    @(negedge clk);
    check("t1_done_low", 32'(done), 32'd0);

    // 2: SHR by 2 with sin=1
    push(4'b1110, 1'b1);
    send(OP_SHR, 3'd2, 4'b0000, 1'b1);
    check("t2_q_e0", 32'(q), 32'b1101);
    check("t2_cout_e0", 32'(cout), 32'd1);
    check("t2_busy_e0", 32'(busy), 32'd1);
    @(negedge clk);
    check("t2_busy_e1", 32'(busy), 32'd0);
    check("t2_done_e1", 32'(done), 32'd1);

    // 3: ROL by WIDTH restores q
    push(4'b1001, 1'b0);
    send(OP_LOAD, 3'd0, 4'b1001, 1'b0);
    push(4'b1001, 1'b1);
    send(OP_ROL, 3'd4, 4'b0000, 1'b0);
    check("t3_q_e0", 32'(q), 32'b0011);
    check("t3_busy_e0", 32'(busy), 32'd1);
    @(negedge clk);
    check("t3_q_e1", 32'(q), 32'b0110);
    check("t3_busy_e1", 32'(busy), 32'd1);
    @(negedge clk);
    check("t3_q_e2", 32'(q), 32'b1100);
    check("t3_busy_e2", 32'(busy), 32'd1);
    @(negedge clk);
    check("t3_busy_e3", 32'(busy), 32'd0);

    // 4: ASR by 3, then CLEAR issued in the done cycle
    push(4'b1000, 1'b0);
    send(OP_LOAD, 3'd0, 4'b1000, 1'b0);
    push(4'b1111, 1'b0);
    send(OP_ASR, 3'd3, 4'b0000, 1'b0);
    check("t4_q_e0", 32'(q), 32'b1100);
    @(negedge clk);
    check("t4_q_e1", 32'(q), 32'b1110);
    @(negedge clk);
    check("t4_done", 32'(done), 32'd1);
    check("t4_ready_in_done", 32'(cmd_ready), 32'd1);
    push(4'b0000, 1'b0);
    send(OP_CLEAR, 3'd0, 4'b0000, 1'b0);

    // 5: SHL aborted after one step; command during busy ignored
    push(4'b0001, 1'b0);
    send(OP_LOAD, 3'd0, 4'b0001, 1'b0);
    send(OP_SHL, 3'd3, 4'b0000, 1'b0);
    check("t5_q_e0", 32'(q), 32'b0010);
    check("t5_busy_e0", 32'(busy), 32'd1);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    op        = OP_LOAD;
    din       = 4'b1111;
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("t5_q_abort", 32'(q), 32'b0010);
    check("t5_cout_abort", 32'(cout), 32'd0);
    check("t5_busy_abort", 32'(busy), 32'd0);
    check("t5_ready_abort", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_q_later", 32'(q), 32'b0010);

    // abort together with cmd_valid in IDLE: command accepted
    push(4'b1010, 1'b0);
    abort = 1'b1;
    send(OP_LOAD, 3'd0, 4'b1010, 1'b0);
    abort = 1'b0;

    // ROR by 7 (more than WIDTH): net rotate-right by 3
    push(4'b0101, 1'b0);
    send(OP_ROR, 3'd7, 4'b0000, 1'b0);
    wait_idle();

    // 6: reset between edges during ROR
    push(4'b0110, 1'b0);
    send(OP_LOAD, 3'd0, 4'b0110, 1'b0);
    send(OP_ROR, 3'd5, 4'b0000, 1'b0);
    check("t6_q_e0", 32'(q), 32'b0011);
    check("t6_busy_e0", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_q_rst", 32'(q), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_ready_rst", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // SHL by 0 and HOLD leave q/cout unchanged but still pulse done
    push(4'b0101, 1'b0);
    send(OP_LOAD, 3'd0, 4'b0101, 1'b0);
    push(4'b0101, 1'b0);
    send(OP_SHL, 3'd0, 4'b0000, 1'b1);
    push(4'b0101, 1'b0);
    send(OP_HOLD, 3'd0, 4'b1111, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
